anton_neopixel_bus_master: RTL and testbench

- Bus initiator that drives the neopixel controller's 8-bit register/buffer bus: busAddr[17:0], byte write/read strobes, busReady.
- Accepts high-level commands from a host adapter (UART/APB front end) over a valid/ready channel.
- Issues correctly spaced single-cycle strobes. Sequences 16-bit delta writes as LOW-then-HIGH pairs.
- Runs auto-incrementing fill bursts and returns read data over a response channel.

---
 rtl/anton_neopixel_bus_master.sv | 231 +++++++++++++++++++++++
 tb/tb_anton_neopixel_bus_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_bus_master.sv
// Bus initiator for the neopixel controller's byte-wide register/buffer bus.
// Turns host commands (byte write, byte read, 16-bit pair write, fill burst) into spaced single-cycle strobes.
module anton_neopixel_bus_master #(
  parameter int TIMEOUT_END = 255,
  parameter int FILL_BITS   = 14
) (
  input  logic                 busClk,
  input  logic                 busRst,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic [1:0]           cmdOp,
  input  logic [17:0]          cmdAddr,
  input  logic [15:0]          cmdData,
  input  logic [FILL_BITS-1:0] cmdCount,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [7:0]           rspData,
  output logic [17:0]          busAddr,
  output logic [7:0]           busDataWr,
  input  logic [7:0]           busDataRd,
  output logic                 busWrite,
  output logic                 busRead,
  input  logic                 busReady,
  output logic                 busy,
  output logic                 errTimeout
);

  localparam int TW = $clog2(TIMEOUT_END + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_END - 1);

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_W16  = 2'b10;
  localparam logic [1:0] OP_FILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GAP   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [1:0]           op_r, op_s;
  logic [17:0]          addr_r, addr_s;
  logic [15:0]          data_r, data_s;
  logic [FILL_BITS-1:0] rem_r, rem_s;
  logic                 half_r, half_s;
  logic [TW-1:0]        tmo_r, tmo_s;
  logic                 cmd_ready_r, rsp_valid_r;
  logic [7:0]           rsp_data_r, rsp_data_s;
  logic [17:0]          bus_addr_r, bus_addr_s;
  logic [7:0]           bus_data_wr_r, bus_data_wr_s;
  logic                 bus_write_r, bus_write_s;
  logic                 bus_read_r, bus_read_s;
  logic                 busy_r;
  logic                 err_r, err_s;
  logic                 abort_s;
  logic                 strobe_out_s;

  // A strobe register that is high means ISSUE has already put its one strobe on the bus.
  assign strobe_out_s = bus_write_r | bus_read_r;

  // Next state, next datapath values and next registered outputs.
  always_comb begin
    state_s       = state_r;
    op_s          = op_r;
    addr_s        = addr_r;
    data_s        = data_r;
    rem_s         = rem_r;
    half_s        = half_r;
    tmo_s         = tmo_r;
    rsp_data_s    = rsp_data_r;
    bus_addr_s    = bus_addr_r;
    bus_data_wr_s = bus_data_wr_r;
    bus_write_s   = 1'b0;
    bus_read_s    = 1'b0;
    err_s         = err_r;
    abort_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmdValid && cmd_ready_r) begin
          op_s    = cmdOp;
          data_s  = cmdData;
          rem_s   = cmdCount;
          half_s  = 1'b0;
          err_s   = 1'b0;
          tmo_s   = {TW{1'b0}};
          state_s = ST_ISSUE;
          if (cmdOp == OP_W16) begin
            addr_s = {cmdAddr[17:1], 1'b0};
          end else begin
            addr_s = cmdAddr;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (strobe_out_s) begin
          state_s = ST_GAP;
        end else if (busReady) begin
          bus_addr_s    = addr_r;
          bus_data_wr_s = half_r ? data_r[15:8] : data_r[7:0];
          if (op_r == OP_RD) begin
            bus_read_s = 1'b1;
          end else begin
            bus_write_s = 1'b1;
          end
        end else if (tmo_r == TMO_LAST) begin
          abort_s = 1'b1;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      ST_GAP: begin
        // The slave answers a read one cycle after the strobe, so it is sampled here.
        if (op_r == OP_RD) begin
          rsp_data_s = busDataRd;
        end else begin
          rsp_data_s = rsp_data_r;
        end
        tmo_s   = {TW{1'b0}};
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (busReady) begin
          if (op_r == OP_RD) begin
            state_s = ST_RESP;
          end else if ((op_r == OP_W16) && !half_r) begin
            half_s    = 1'b1;
            addr_s[0] = 1'b1;
            tmo_s     = {TW{1'b0}};
            state_s   = ST_ISSUE;
          end else if ((op_r == OP_FILL) && (rem_r != {FILL_BITS{1'b0}})) begin
            rem_s   = rem_r - FILL_BITS'(1);
            addr_s  = {addr_r[17:16], addr_r[15:0] + 16'd1};
            tmo_s   = {TW{1'b0}};
            state_s = ST_ISSUE;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (tmo_r == TMO_LAST) begin
          abort_s = 1'b1;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      ST_RESP: begin
        if (rspReady) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // An abort drops whatever is left of the command, including a pending pair half or burst.
    if (abort_s) begin
      err_s = 1'b1;
      if (op_r == OP_RD) begin
        rsp_data_s = 8'hFF;
        state_s    = ST_RESP;
      end else begin
        state_s = ST_IDLE;
      end
    end else begin
      err_s = err_s;
    end
  end

  // State register.
  always_ff @(posedge busClk) begin
    if (busRst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs; handshake flags are derived from the next state.
  always_ff @(posedge busClk) begin
    if (busRst) begin
      op_r          <= 2'b00;
      addr_r        <= 18'd0;
      data_r        <= 16'd0;
      rem_r         <= {FILL_BITS{1'b0}};
      half_r        <= 1'b0;
      tmo_r         <= {TW{1'b0}};
      cmd_ready_r   <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= 8'h00;
      bus_addr_r    <= 18'd0;
      bus_data_wr_r <= 8'h00;
      bus_write_r   <= 1'b0;
      bus_read_r    <= 1'b0;
      busy_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      op_r          <= op_s;
      addr_r        <= addr_s;
      data_r        <= data_s;
      rem_r         <= rem_s;
      half_r        <= half_s;
      tmo_r         <= tmo_s;
      cmd_ready_r   <= (state_s == ST_IDLE);
      rsp_valid_r   <= (state_s == ST_RESP);
      rsp_data_r    <= rsp_data_s;
      bus_addr_r    <= bus_addr_s;
      bus_data_wr_r <= bus_data_wr_s;
      bus_write_r   <= bus_write_s;
      bus_read_r    <= bus_read_s;
      busy_r        <= (state_s != ST_IDLE);
      err_r         <= err_s;
    end
  end

  assign cmdReady   = cmd_ready_r;
  assign rspValid   = rsp_valid_r;
  assign rspData    = rsp_data_r;
  assign busAddr    = bus_addr_r;
  assign busDataWr  = bus_data_wr_r;
  assign busWrite   = bus_write_r;
  assign busRead    = bus_read_r;
  assign busy       = busy_r;
  assign errTimeout = err_r;

endmodule

// File: tb/tb_anton_neopixel_bus_master.sv
// Self-checking bench: a simple stalling slave, a strobe monitor and a command-level model
// that lists the bus accesses and completion latency each command should produce.
module tb_anton_neopixel_bus_master;

  localparam int FB = 14;

  logic          busClk = 1'b0;
  logic          busRst = 1'b1;
  logic          cmdValid = 1'b0;
  logic          cmdReady;
  logic [1:0]    cmdOp = 2'b00;
  logic [17:0]   cmdAddr = 18'd0;
  logic [15:0]   cmdData = 16'd0;
  logic [FB-1:0] cmdCount = '0;
  logic          rspValid;
  logic          rspReady = 1'b0;
  logic [7:0]    rspData;
  logic [17:0]   busAddr;
  logic [7:0]    busDataWr;
  logic [7:0]    busDataRd = 8'h00;
  logic          busWrite;
  logic          busRead;
  logic          busReady;
  logic          busy;
  logic          errTimeout;

  anton_neopixel_bus_master #(.TIMEOUT_END(15), .FILL_BITS(FB)) dut (
    .busClk(busClk), .busRst(busRst),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdAddr(cmdAddr),
    .cmdData(cmdData), .cmdCount(cmdCount),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .busAddr(busAddr), .busDataWr(busDataWr), .busDataRd(busDataRd),
    .busWrite(busWrite), .busRead(busRead), .busReady(busReady),
    .busy(busy), .errTimeout(errTimeout)
  );

  always #5 busClk = ~busClk;

  int cyc = 0;
  always @(posedge busClk) cyc <= cyc + 1;

  // Slave: drops ready for stall_len cycles after each strobe, returns rd_value after a read.
  int         stall_len = 0;
  int         stall_left = 0;
  logic       force_low = 1'b0;
  logic [7:0] rd_value = 8'h00;
  always @(posedge busClk) begin
    if (busWrite || busRead) begin
      stall_left <= stall_len;
      if (busRead) busDataRd <= rd_value;
    end else if (stall_left > 0) begin
      stall_left <= stall_left - 1;
    end
  end
  assign busReady = !force_low && (stall_left == 0);

  // Monitor: records every strobe and counts protocol violations.
  logic [26:0] mon_q[$];
  logic [26:0] exp_q[$];
  logic        prev_strobe = 1'b0;
  int          viol = 0;
  always @(posedge busClk) begin
    if (busRst) begin
      prev_strobe <= 1'b0;
    end else begin
      if (busWrite && busRead) viol <= viol + 1;
      else if (prev_strobe && (busWrite || busRead)) viol <= viol + 1;
      if (busWrite || busRead) mon_q.push_back({busRead, busAddr, busRead ? 8'h00 : busDataWr});
      prev_strobe <= busWrite || busRead;
    end
  end

  int n_total = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmdReady"}, {31'd0, cmdReady}, 32'd0);
    check({tag, "_rspValid"}, {31'd0, rspValid}, 32'd0);
    check({tag, "_rspData"}, {24'd0, rspData}, 32'd0);
    check({tag, "_busAddr"}, {14'd0, busAddr}, 32'd0);
    check({tag, "_busDataWr"}, {24'd0, busDataWr}, 32'd0);
    check({tag, "_strobes"}, {30'd0, busWrite, busRead}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, errTimeout}, 32'd0);
  endtask

  // Issue one command and check accesses, latency, response and final status.
  // stall > 16 makes the slave time out the first WAIT; fl holds ready low from the start.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [17:0] addr,
                         input logic [15:0] data, input logic [FB-1:0] cnt, input int stall,
                         input logic fl, input logic [7:0] rdv, input int rdly);
    int k, c, m, n, exp_lat;
    bit done;
    logic [15:0] lo;
    logic [7:0] exp_rd;
    logic exp_err;
    exp_q.delete();
    case (op)
      2'b00: exp_q.push_back({1'b0, addr, data[7:0]});
      2'b01: exp_q.push_back({1'b1, addr, 8'h00});
      2'b10: begin
        exp_q.push_back({1'b0, addr[17:1], 1'b0, data[7:0]});
        exp_q.push_back({1'b0, addr[17:1], 1'b1, data[15:8]});
      end
      default: begin
        for (int i = 0; i <= int'(cnt); i++) begin
          lo = addr[15:0] + 16'(i);
          exp_q.push_back({1'b0, addr[17:16], lo, data[7:0]});
        end
      end
    endcase
    n = exp_q.size();
    exp_err = 1'b0;
    exp_rd = rdv;
    if (fl) begin
      exp_q.delete();
      exp_lat = 15;
      exp_err = 1'b1;
      exp_rd = 8'hFF;
    end else if (stall > 16) begin
      while (exp_q.size() > 1) exp_q.pop_back();
      exp_lat = 18;
      exp_err = 1'b1;
      exp_rd = 8'hFF;
    end else begin
      exp_lat = n * (4 + ((stall == 2) ? 1 : 0));
    end
    mon_q.delete();
    stall_len = stall;
    force_low = fl;
    rd_value = rdv;
    cmdOp = op; cmdAddr = addr; cmdData = data; cmdCount = cnt;
    cmdValid = 1'b1;
    for (int t = 0; t < 50 && !cmdReady; t++) @(negedge busClk);
    k = cyc;
    @(posedge busClk);
    #1 cmdValid = 1'b0;
    c = k + 1;
    @(negedge busClk);
    check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    check({tag, "_err_cleared"}, {31'd0, errTimeout}, 32'd0);
    done = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if ((op == 2'b01) ? rspValid : cmdReady) begin
        done = 1'b1;
        break;
      end
      @(negedge busClk);
    end
    m = cyc;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_latency"}, m - c, exp_lat);
    if (op == 2'b01) begin
      for (int i = 0; i < rdly; i++) begin
        check({tag, "_rsp_hold"}, {23'd0, rspValid, rspData}, {23'd0, 1'b1, exp_rd});
        @(negedge busClk);
      end
      check({tag, "_rspData"}, {24'd0, rspData}, {24'd0, exp_rd});
      rspReady = 1'b1;
      @(posedge busClk);
      #1 rspReady = 1'b0;
      @(negedge busClk);
    end
    check({tag, "_end_status"}, {28'd0, cmdReady, busy, rspValid, errTimeout},
          {28'd0, 1'b1, 1'b0, 1'b0, exp_err});
    check({tag, "_n_strobes"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++)
      check({tag, "_strobe"}, {5'd0, mon_q[i]}, {5'd0, exp_q[i]});
    force_low = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [17:0] ra;
    logic [15:0] rd16;
    logic [7:0]  rv;
    repeat (3) @(posedge busClk);
    @(negedge busClk);
    check_reset("reset");
    @(posedge busClk);
    #1 busRst = 1'b0;
    repeat (2) @(negedge busClk);
    check("ready_after_reset", {31'd0, cmdReady}, 32'd1);

    run_cmd("wr_byte", 2'b00, 18'h20005, 16'h00AB, '0, 0, 1'b0, 8'h00, 0);
    run_cmd("rd_byte", 2'b01, 18'h30002, 16'h0000, '0, 0, 1'b0, 8'h15, 5);
    run_cmd("wr16", 2'b10, 18'h10007, 16'h1234, '0, 0, 1'b0, 8'h00, 0);
    run_cmd("fill_wrap", 2'b11, 18'h2FFFE, 16'h007F, FB'(3), 0, 1'b0, 8'h00, 0);
    run_cmd("wr_stall2", 2'b00, 18'h3A001, 16'h00C3, '0, 2, 1'b0, 8'h00, 0);
    run_cmd("rd_stall2", 2'b01, 18'h00010, 16'h0000, '0, 2, 1'b0, 8'hA5, 1);
    run_cmd("fill_tmo", 2'b11, 18'h00100, 16'h0055, FB'(3), 40, 1'b0, 8'h00, 0);
    repeat (30) @(negedge busClk);
    run_cmd("rd_tmo", 2'b01, 18'h20040, 16'h0000, '0, 0, 1'b1, 8'h42, 2);
    run_cmd("after_tmo", 2'b00, 18'h00001, 16'h0011, '0, 0, 1'b0, 8'h00, 0);

    // Reset during the GAP cycle of a read.
    rd_value = 8'h3C; stall_len = 0;
    cmdOp = 2'b01; cmdAddr = 18'h30002; cmdValid = 1'b1;
    for (int t = 0; t < 50 && !cmdReady; t++) @(negedge busClk);
    @(posedge busClk);
    #1 cmdValid = 1'b0;
    @(posedge busClk);
    @(posedge busClk);
    #1 busRst = 1'b1;
    @(negedge busClk);
    check("gap_before_reset_edge_busy", {31'd0, busy}, 32'd1);
    @(negedge busClk);
    check_reset("mid_reset");
    repeat (2) @(negedge busClk);
    check("mid_reset_no_rsp", {31'd0, rspValid}, 32'd0);
    @(posedge busClk);
    #1 busRst = 1'b0;
    repeat (2) @(negedge busClk);
    run_cmd("post_reset_wr", 2'b00, 18'h1FFFF, 16'h005A, '0, 0, 1'b0, 8'h00, 0);

    for (int i = 0; i < 24; i++) begin
      r = $urandom; ra = r[17:0];
      if ($urandom_range(0, 3) == 0) ra[15:0] = 16'hFFFD;
      r = $urandom; rd16 = r[15:0];
      r = $urandom; rv = r[7:0];
      run_cmd("rand", 2'($urandom_range(0, 3)), ra, rd16, FB'($urandom_range(0, 5)),
              2 * int'($urandom_range(0, 1)), 1'b0, rv, int'($urandom_range(0, 4)));
    end

    check("protocol_violations", viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
